// File: rtl/prefetch_issue_queue_if.sv
// rtl/prefetch_issue_queue_if.sv - predicted-PC input and I-mem prefetch handshake bundle
interface prefetch_issue_queue_if #(
    parameter int ADDRESS_BITS = 20
);
    logic                    in_valid;
    logic [ADDRESS_BITS-1:0] in_pc;
    logic                    mem_req;
    logic [ADDRESS_BITS-1:0] mem_addr;
    logic                    mem_gnt;
    logic                    mem_resp;

    modport master (
        output in_valid, in_pc, mem_gnt, mem_resp,
        input  mem_req, mem_addr
    );

    modport slave (
        input  in_valid, in_pc, mem_gnt, mem_resp,
        output mem_req, mem_addr
    );
endinterface

// File: rtl/prefetch_issue_queue.sv
// rtl/prefetch_issue_queue.sv - line-aligning, deduplicating prefetch FIFO with req/gnt/resp issue FSM
module prefetch_issue_queue #(
    parameter int ADDRESS_BITS = 20,
    parameter int DEPTH        = 4,
    parameter int LINE_BITS    = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     in_done_i,
    input  logic                     flush_i,
    prefetch_issue_queue_if.slave    bus,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     busy_o,
    output logic                     seq_idle_o,
    output logic [7:0]               drop_cnt_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDRESS_BITS-1:0] LINE_MASK =
        ~((ADDRESS_BITS'(1) << LINE_BITS) - ADDRESS_BITS'(1));

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

    state_e                  state_q, state_d;
    logic [ADDRESS_BITS-1:0] fifo_q [DEPTH];
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [ADDRESS_BITS-1:0] addr_q, addr_d;
    logic                    done_flag_q, done_flag_d;
    logic [7:0]              drop_q, drop_d;
    logic [ADDRESS_BITS-1:0] aligned;
    logic [PTR_W-1:0]        offset;
    logic                    dup, pop, push, drop;

    assign aligned = bus.in_pc & LINE_MASK;

    // An entry is live when its distance from the read pointer is below count.
    always_comb begin
        dup    = (state_q != S_IDLE) && (aligned == addr_q);
        offset = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset = PTR_W'(i) - rd_ptr_q;
            if (({1'b0, offset} < count_q) && (fifo_q[i] == aligned)) begin
                dup = 1'b1;
            end
        end
    end

    assign pop  = (state_q == S_IDLE) && (count_q != '0) && !flush_i;
    assign push = bus.in_valid && !flush_i && !dup && ((count_q != CNT_W'(DEPTH)) || pop);
    assign drop = bus.in_valid && !flush_i && !push;

    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        state_d     = state_q;
        addr_d      = addr_q;
        drop_d      = drop_q;
        done_flag_d = done_flag_q;

        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end

        if (drop && (drop_q != 8'hff)) drop_d = drop_q + 8'd1;

        if (push)           done_flag_d = 1'b0;
        else if (in_done_i) done_flag_d = 1'b1;

        case (state_q)
            S_IDLE: if (pop) begin
                addr_d  = fifo_q[rd_ptr_q];
                state_d = S_REQ;
            end
            S_REQ:   if (bus.mem_gnt)  state_d = S_WAIT;
            S_WAIT:  if (bus.mem_resp) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            addr_q      <= '0;
            drop_q      <= '0;
            done_flag_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            addr_q      <= addr_d;
            drop_q      <= drop_d;
            done_flag_q <= done_flag_d;
        end
    end

    // Storage needs no reset: liveness is tracked by pointers and count alone.
    always_ff @(posedge clk_i) begin
        if (!rst_i && push) fifo_q[wr_ptr_q] <= aligned;
    end

    assign bus.mem_req  = (state_q == S_REQ);
    assign bus.mem_addr = addr_q;
    assign count_o      = count_q;
    assign busy_o       = (count_q != '0) || (state_q != S_IDLE);
    assign seq_idle_o   = done_flag_q && (count_q == '0) && (state_q == S_IDLE);
    assign drop_cnt_o   = drop_q;
endmodule

// File: tb/tb_prefetch_issue_queue.sv
// tb/tb_prefetch_issue_queue.sv - directed and randomized checks against a queue-based reference model
module tb_prefetch_issue_queue;
    logic       clk = 1'b0;
    logic       rst, in_done, flush;
    logic [2:0] count;
    logic       busy, seq_idle;
    logic [7:0] drop_cnt;

    always #5 clk = ~clk;

    prefetch_issue_queue_if #(.ADDRESS_BITS(20)) bus ();

    prefetch_issue_queue #(.ADDRESS_BITS(20), .DEPTH(4), .LINE_BITS(2)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .in_done_i  (in_done),
        .flush_i    (flush),
        .bus        (bus),
        .count_o    (count),
        .busy_o     (busy),
        .seq_idle_o (seq_idle),
        .drop_cnt_o (drop_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: queue of aligned lines plus an issue phase (0 idle, 1 requesting, 2 waiting)
    logic [19:0] mq[$];
    int          m_state = 0;
    logic [19:0] m_addr  = '0;
    bit          m_flag  = 1'b0;
    int          m_drop  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic compare_all();
        check("mem_req",  32'(bus.mem_req),  32'(m_state == 1));
        check("mem_addr", 32'(bus.mem_addr), 32'(m_addr));
        check("count",    32'(count),        32'(mq.size()));
        check("busy",     32'(busy),         32'(mq.size() != 0 || m_state != 0));
        check("seq_idle", 32'(seq_idle),     32'(m_flag && mq.size() == 0 && m_state == 0));
        check("drop_cnt", 32'(drop_cnt),     32'(m_drop));
    endtask

    task automatic model_step(input bit r, input bit v, input logic [19:0] pc,
                              input bit d, input bit f, input bit g, input bit rs);
        logic [19:0] a;
        bit          dup, pop, acc;
        if (r) begin
            mq.delete();
            m_state = 0;
            m_addr  = '0;
            m_flag  = 1'b0;
            m_drop  = 0;
            return;
        end
        a   = pc & 20'hffffc;
        dup = (m_state != 0) && (a == m_addr);
        foreach (mq[i]) if (mq[i] == a) dup = 1'b1;
        pop = (m_state == 0) && (mq.size() > 0) && !f;
        acc = v && !f && !dup && ((mq.size() < 4) || pop);
        if (v && !f && !acc && m_drop < 255) m_drop++;
        if (acc)    m_flag = 1'b0;
        else if (d) m_flag = 1'b1;
        case (m_state)
            0: if (pop) begin m_addr = mq.pop_front(); m_state = 1; end
            1: if (g) m_state = 2;
            2: if (rs) m_state = 0;
            default: m_state = 0;
        endcase
        if (f)   mq.delete();
        if (acc) mq.push_back(a);
    endtask

    task automatic tick(input bit r, input bit v, input logic [19:0] pc,
                        input bit d, input bit f, input bit g, input bit rs);
        rst          = r;
        bus.in_valid = v;
        bus.in_pc    = pc;
        in_done      = d;
        flush        = f;
        bus.mem_gnt  = g;
        bus.mem_resp = rs;
        model_step(r, v, pc, d, f, g, rs);
        @(negedge clk);
        compare_all();
    endtask

    logic [19:0] issued[$];
    logic [19:0] order[4];

    initial begin
        rst = 1'b1; in_done = 1'b0; flush = 1'b0;
        bus.in_valid = 1'b0; bus.in_pc = '0; bus.mem_gnt = 1'b0; bus.mem_resp = 1'b0;
        @(negedge clk);

        // Reset with in_valid toggling, then release
        for (int i = 0; i < 5; i++) tick(1, i[0], 20'h00123, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0, 0);
        check("reset_req",  32'(bus.mem_req),  0);
        check("reset_busy", 32'(busy),         0);
        check("reset_cnt",  32'(count),        0);

        // Single issue
        tick(0, 1, 20'hb000f, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0, 0);
        check("single_req",  32'(bus.mem_req),  1);
        check("single_addr", 32'(bus.mem_addr), 32'h000b000c);
        tick(0, 0, 0, 0, 0, 1, 0);
        tick(0, 0, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0, 1);
        check("single_busy", 32'(busy), 0);

        // Dedup against in-flight line
        tick(1, 0, 0, 0, 0, 0, 0);
        tick(0, 1, 20'hb0010, 0, 0, 0, 0);
        tick(0, 1, 20'hb0013, 0, 0, 0, 0);
        tick(0, 1, 20'hb0014, 0, 0, 0, 0);
        check("dedup_cnt",  32'(count),        1);
        check("dedup_drop", 32'(drop_cnt),     1);
        check("dedup_addr", 32'(bus.mem_addr), 32'h000b0010);

        // Full queue and issue order
        tick(1, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 6; i++) tick(0, 1, 20'(i * 'h100), 0, 0, 0, 0);
        check("full_cnt",  32'(count),        4);
        check("full_drop", 32'(drop_cnt),     1);
        check("full_addr", 32'(bus.mem_addr), 32'h100);
        issued.delete();
        for (int i = 0; i < 16; i++) begin
            tick(0, 0, 0, 0, 0, 1, 1);
            if (bus.mem_req) issued.push_back(bus.mem_addr);
        end
        order = '{20'h200, 20'h300, 20'h400, 20'h500};
        check("full_nissued", 32'(issued.size()), 4);
        for (int i = 0; i < 4; i++)
            check("full_order", 32'((i < issued.size()) ? issued[i] : 20'hfffff), 32'(order[i]));

        // Flush with coincident push while a request waits
        tick(1, 0, 0, 0, 0, 0, 0);
        tick(0, 1, 20'h010, 0, 0, 0, 0);
        tick(0, 1, 20'h020, 0, 0, 0, 0);
        tick(0, 1, 20'h030, 0, 0, 1, 0);
        tick(0, 1, 20'h040, 0, 0, 0, 0);
        check("flush_pre_cnt", 32'(count), 3);
        tick(0, 1, 20'h050, 0, 1, 0, 0);
        check("flush_cnt",  32'(count),    0);
        check("flush_drop", 32'(drop_cnt), 0);
        check("flush_busy", 32'(busy),     1);
        tick(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 0, 1, 1);
        check("flush_idle_req", 32'(bus.mem_req), 0);
        check("flush_idle_busy", 32'(busy),       0);

        // Drop counter saturation and seq_idle
        tick(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 300; i++) tick(0, 1, 20'h701, 0, 0, 0, 0);
        check("sat_drop", 32'(drop_cnt), 255);
        tick(0, 0, 0, 0, 0, 1, 0);
        tick(0, 0, 0, 0, 0, 0, 1);
        tick(0, 0, 0, 1, 0, 0, 0);
        check("seq_idle_set", 32'(seq_idle), 1);
        tick(0, 1, 20'h800, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) tick(0, 0, 0, 0, 0, 1, 1);
        check("seq_idle_clr", 32'(seq_idle), 0);

        // Randomized traffic with a narrow address set to provoke duplicates and fullness
        tick(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4000; i++) begin
            tick($urandom_range(0, 299) == 0,
                 $urandom_range(0, 1) == 1,
                 20'h400 + 20'($urandom_range(0, 5) << 2) + 20'($urandom_range(0, 3)),
                 $urandom_range(0, 15) == 0,
                 $urandom_range(0, 39) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
